// File: rtl/rstseq_pkg.sv
// Shared types and width helpers for the reset sequencer.
package rstseq_pkg;

    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        WAIT_LOCK  = 3'd1,
        GAP        = 3'd2,
        WAIT_DONE  = 3'd3,
        RUN        = 3'd4,
        FAULT      = 3'd5
    } rstseq_state_t;

    function automatic int idx_width(input int num_stages);
        return (num_stages > 1) ? $clog2(num_stages) : 1;
    endfunction

    // One shared counter serves hold, gap and done-timeout timing.
    function automatic int cnt_width(input int deb, input int gap, input int tmo);
        int w;
        w = $clog2(deb + 1);
        if ($clog2(gap + 1) > w) w = $clog2(gap + 1);
        if ($clog2(tmo + 1) > w) w = $clog2(tmo + 1);
        return w;
    endfunction

endpackage

// File: rtl/rstseq_debounce.sv
// Synchroniser plus debounce counter for the board reset key.
// The debounced level resets to 0 (key pressed) and flips after DEBOUNCE_CYCLES stable cycles.
module rstseq_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_raw,
    output logic o_level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign o_level  = r_level;

    // Any return to the current level clears the count, so only an unbroken run flips it.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            if (w_synced == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= w_synced;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset release: debounced key, PLL locks, then per-stage gap/done handshake.
// Define RSTSEQ_TIMEOUT_EN to add the WAIT_DONE timeout and the FAULT state.
module reset_sequencer
    import rstseq_pkg::*;
#(
    parameter int NUM_STAGES      = 3,
    parameter int NUM_LOCK        = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STAGE_GAP       = 16,
    parameter int DONE_TIMEOUT    = 16777216,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 key_n_i,
    input  logic                                 soft_rst_req_i,
    input  logic [NUM_LOCK-1:0]                  pll_lock_i,
    input  logic [NUM_STAGES-1:0]                stage_done_i,
    output logic [NUM_STAGES-1:0]                rstn_o,
    output logic [idx_width(NUM_STAGES)-1:0]     stage_idx_o,
    output logic                                 seq_busy_o,
    output logic                                 fault_o,
    output rstseq_state_t                        state_o
);

    localparam int IDX_W = idx_width(NUM_STAGES);
    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, STAGE_GAP, DONE_TIMEOUT);

    logic [NUM_LOCK-1:0]   r_lock_sync [SYNC_STAGES];
    logic [NUM_STAGES-1:0] r_done_sync [SYNC_STAGES];

    rstseq_state_t         r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_STAGES-1:0] r_rstn;
    logic                  r_busy;

    logic                  w_key_level;
    logic                  w_key_pressed;
    logic                  w_locks_ok;
    logic [NUM_STAGES-1:0] w_done;
    logic                  w_abort_req;
    logic                  w_lock_abort;
    logic                  w_hold_done;

    rstseq_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_raw  (key_n_i),
        .o_level(w_key_level)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_lock_sync[i] <= '0;
                r_done_sync[i] <= '0;
            end
        end else begin
            r_lock_sync[0] <= pll_lock_i;
            r_done_sync[0] <= stage_done_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_lock_sync[i] <= r_lock_sync[i-1];
                r_done_sync[i] <= r_done_sync[i-1];
            end
        end
    end

    assign w_key_pressed = ~w_key_level;
    assign w_locks_ok    = &r_lock_sync[SYNC_STAGES-1];
    assign w_done        = r_done_sync[SYNC_STAGES-1];
    assign w_abort_req   = w_key_pressed | soft_rst_req_i;
    // Lock loss only aborts once the sequence has left WAIT_LOCK.
    assign w_lock_abort  = w_abort_req | ~w_locks_ok;
    assign w_hold_done   = (r_cnt >= CNT_W'(STAGE_GAP));

`ifdef RSTSEQ_TIMEOUT_EN
    logic r_fault;
    assign fault_o = r_fault;
`else
    assign fault_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= RESET_HOLD;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_rstn  <= '0;
            r_busy  <= 1'b1;
`ifdef RSTSEQ_TIMEOUT_EN
            r_fault <= 1'b0;
`endif
        end else begin
            case (r_state)
                RESET_HOLD: begin
                    r_rstn <= '0;
                    r_idx  <= '0;
                    if (soft_rst_req_i) begin
                        r_cnt <= '0;
                    end else if (w_hold_done && !w_key_pressed) begin
                        r_state <= WAIT_LOCK;
                    end else if (!w_hold_done) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (w_abort_req) begin
                        r_state <= RESET_HOLD;
                        r_cnt   <= '0;
                    end else if (w_locks_ok) begin
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (w_lock_abort) begin
                        r_state <= RESET_HOLD;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_rstn  <= '0;
                    end else if (r_cnt == CNT_W'(STAGE_GAP)) begin
                        r_rstn[r_idx] <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= WAIT_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (w_lock_abort) begin
                        r_state <= RESET_HOLD;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_rstn  <= '0;
                    end else if (w_done[r_idx]) begin
                        if (r_idx == IDX_W'(NUM_STAGES - 1)) begin
                            r_state <= RUN;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_cnt   <= '0;
                            r_state <= GAP;
                        end
`ifdef RSTSEQ_TIMEOUT_EN
                    end else if (r_cnt >= CNT_W'(DONE_TIMEOUT - 1)) begin
                        r_state <= FAULT;
                        r_rstn  <= '0;
                        r_fault <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                RUN: begin
                    if (w_lock_abort) begin
                        r_state <= RESET_HOLD;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_rstn  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
`ifdef RSTSEQ_TIMEOUT_EN
                FAULT: begin
                    r_rstn <= '0;
                    r_idx  <= '0;
                    if (w_abort_req) begin
                        r_state <= RESET_HOLD;
                        r_cnt   <= '0;
                        r_fault <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state <= RESET_HOLD;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_rstn  <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign rstn_o      = r_rstn;
    assign stage_idx_o = r_idx;
    assign seq_busy_o  = r_busy;
    assign state_o     = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: boot latency, bounce, aborts, timeout, done ordering.
module tb_reset_sequencer;
    import rstseq_pkg::*;

    localparam int NUM_STAGES      = 3;
    localparam int NUM_LOCK        = 2;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam int STAGE_GAP       = 4;
    localparam int DONE_TIMEOUT    = 64;
    localparam int SYNC_STAGES     = 2;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  key_n_i;
    logic                  soft_rst_req_i;
    logic [NUM_LOCK-1:0]   pll_lock_i;
    logic [NUM_STAGES-1:0] stage_done_i;
    logic [NUM_STAGES-1:0] rstn_o;
    logic [1:0]            stage_idx_o;
    logic                  seq_busy_o;
    logic                  fault_o;
    rstseq_state_t         state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_STAGES     (NUM_STAGES),
        .NUM_LOCK       (NUM_LOCK),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .STAGE_GAP      (STAGE_GAP),
        .DONE_TIMEOUT   (DONE_TIMEOUT),
        .SYNC_STAGES    (SYNC_STAGES)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .key_n_i       (key_n_i),
        .soft_rst_req_i(soft_rst_req_i),
        .pll_lock_i    (pll_lock_i),
        .stage_done_i  (stage_done_i),
        .rstn_o        (rstn_o),
        .stage_idx_o   (stage_idx_o),
        .seq_busy_o    (seq_busy_o),
        .fault_o       (fault_o),
        .state_o       (state_o)
    );

    // n = index of the first edge (0 = next edge) after which the selected output equals target; -1 if never.
    task automatic wait_for(input int sel, input logic [2:0] target, input int limit, output int n);
        logic [2:0] obs;
        n = -1;
        for (int e = 0; e < limit; e++) begin
            @(posedge clk); #1;
            case (sel)
                0:       obs = rstn_o;
                1:       obs = {2'b00, seq_busy_o};
                default: obs = {2'b00, fault_o};
            endcase
            if (obs === target) begin
                n = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; key_n_i = 1'b0; soft_rst_req_i = 1'b0;
        pll_lock_i = 2'b11; stage_done_i = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rstn_o !== 3'b000) begin errors++; $display("FAIL reset_rstn: got %b expected 000", rstn_o); end
        checks++; if (stage_idx_o !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", stage_idx_o); end
        checks++; if (seq_busy_o !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", seq_busy_o); end
        checks++; if (fault_o !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault_o); end
        checks++; if (state_o !== RESET_HOLD) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_o, RESET_HOLD); end
        rstn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (rstn_o !== 3'b000) begin errors++; $display("FAIL hold_while_pressed: got %b expected 000", rstn_o); end
    endtask

    task automatic test_nominal_boot();
        int n;
        key_n_i = 1'b1;
        wait_for(0, 3'b001, 40, n);
        checks++; if (n !== 16) begin errors++; $display("FAIL boot_stage0_latency: got %0d expected 16", n); end
        checks++; if (stage_idx_o !== 2'd0) begin errors++; $display("FAIL boot_idx0: got %0d expected 0", stage_idx_o); end
        repeat (9) @(posedge clk);
        #1 stage_done_i[0] = 1'b1;
        wait_for(0, 3'b011, 30, n);
        checks++; if (n !== 7) begin errors++; $display("FAIL boot_stage1_latency: got %0d expected 7", n); end
        checks++; if (stage_idx_o !== 2'd1) begin errors++; $display("FAIL boot_idx1: got %0d expected 1", stage_idx_o); end
        repeat (9) @(posedge clk);
        #1 stage_done_i[1] = 1'b1;
        wait_for(0, 3'b111, 30, n);
        checks++; if (n !== 7) begin errors++; $display("FAIL boot_stage2_latency: got %0d expected 7", n); end
        checks++; if (stage_idx_o !== 2'd2) begin errors++; $display("FAIL boot_idx2: got %0d expected 2", stage_idx_o); end
        checks++; if (seq_busy_o !== 1'b1) begin errors++; $display("FAIL boot_busy_before_done2: got %b expected 1", seq_busy_o); end
        repeat (9) @(posedge clk);
        #1 stage_done_i[2] = 1'b1;
        wait_for(1, 3'b000, 20, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL boot_busy_fall: got %0d expected 2", n); end
        checks++; if (state_o !== RUN) begin errors++; $display("FAIL boot_state_run: got %0d expected %0d", state_o, RUN); end
    endtask

    task automatic test_lock_loss();
        int n;
        pll_lock_i = 2'b01;
        @(posedge clk);
        #1 pll_lock_i = 2'b11;
        checks++; if (rstn_o !== 3'b111) begin errors++; $display("FAIL lock_loss_early: got %b expected 111", rstn_o); end
        wait_for(0, 3'b000, 10, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL lock_loss_latency: got %0d expected 1", n); end
        checks++; if (state_o !== RESET_HOLD) begin errors++; $display("FAIL lock_loss_state: got %0d expected %0d", state_o, RESET_HOLD); end
        checks++; if (stage_idx_o !== 2'd0) begin errors++; $display("FAIL lock_loss_idx: got %0d expected 0", stage_idx_o); end
        wait_for(1, 3'b000, 200, n);
        checks++; if (n < 0) begin errors++; $display("FAIL lock_loss_resequence: got %0d expected completion", n); end
        checks++; if (rstn_o !== 3'b111) begin errors++; $display("FAIL lock_loss_run_rstn: got %b expected 111", rstn_o); end
    endtask

    task automatic test_key_bounce();
        int n;
        int bad;
        key_n_i = 1'b0;
        wait_for(0, 3'b000, 30, n);
        checks++; if (n !== 10) begin errors++; $display("FAIL key_press_abort: got %0d expected 10", n); end
        stage_done_i = 3'b000;
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            if (c % 5 == 0) key_n_i = ~key_n_i;
            @(posedge clk); #1;
            if (rstn_o !== 3'b000 || state_o !== RESET_HOLD) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bounce_held: got %0d bad cycles expected 0", bad); end
        key_n_i = 1'b1;
        wait_for(0, 3'b001, 40, n);
        checks++; if (n !== 16) begin errors++; $display("FAIL bounce_release_latency: got %0d expected 16", n); end
    endtask

    task automatic test_soft_vs_done();
        int n;
        stage_done_i[0] = 1'b1;
        wait_for(0, 3'b011, 20, n);
        checks++; if (n !== 7) begin errors++; $display("FAIL soft_setup_stage1: got %0d expected 7", n); end
        stage_done_i[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 soft_rst_req_i = 1'b1;
        @(posedge clk);
        #1 soft_rst_req_i = 1'b0;
        checks++; if (rstn_o !== 3'b000) begin errors++; $display("FAIL soft_wins_rstn: got %b expected 000", rstn_o); end
        checks++; if (stage_idx_o !== 2'd0) begin errors++; $display("FAIL soft_wins_idx: got %0d expected 0", stage_idx_o); end
        checks++; if (state_o !== RESET_HOLD) begin errors++; $display("FAIL soft_wins_state: got %0d expected %0d", state_o, RESET_HOLD); end
        checks++; if (seq_busy_o !== 1'b1) begin errors++; $display("FAIL soft_wins_busy: got %b expected 1", seq_busy_o); end
        stage_done_i = 3'b000;
    endtask

    task automatic test_timeout();
        int n;
        int bad;
        wait_for(0, 3'b001, 40, n);
        checks++; if (n < 0) begin errors++; $display("FAIL timeout_setup_stage0: got %0d expected release", n); end
        stage_done_i[0] = 1'b1;
        wait_for(0, 3'b011, 20, n);
        checks++; if (n !== 7) begin errors++; $display("FAIL timeout_setup_stage1: got %0d expected 7", n); end
`ifdef RSTSEQ_TIMEOUT_EN
        wait_for(2, 3'b001, 100, n);
        checks++; if (n !== DONE_TIMEOUT - 1) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", n, DONE_TIMEOUT - 1); end
        checks++; if (rstn_o !== 3'b000) begin errors++; $display("FAIL timeout_rstn: got %b expected 000", rstn_o); end
        checks++; if (state_o !== FAULT) begin errors++; $display("FAIL timeout_state: got %0d expected %0d", state_o, FAULT); end
        key_n_i = 1'b0;
        wait_for(2, 3'b000, 30, n);
        checks++; if (n !== 10) begin errors++; $display("FAIL fault_clear_latency: got %0d expected 10", n); end
        checks++; if (state_o !== RESET_HOLD) begin errors++; $display("FAIL fault_clear_state: got %0d expected %0d", state_o, RESET_HOLD); end
`else
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (fault_o !== 1'b0 || rstn_o !== 3'b011 || state_o !== WAIT_DONE) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL no_timeout_wait: got %0d bad cycles expected 0", bad); end
        key_n_i = 1'b0;
        wait_for(0, 3'b000, 30, n);
        checks++; if (n !== 10) begin errors++; $display("FAIL no_timeout_key_abort: got %0d expected 10", n); end
`endif
        stage_done_i = 3'b000;
    endtask

    task automatic test_out_of_order_done();
        int n;
        stage_done_i = 3'b100;
        key_n_i = 1'b1;
        wait_for(0, 3'b001, 40, n);
        checks++; if (n !== 16) begin errors++; $display("FAIL ooo_stage0_latency: got %0d expected 16", n); end
        stage_done_i[0] = 1'b1;
        wait_for(0, 3'b011, 20, n);
        checks++; if (n !== 7) begin errors++; $display("FAIL ooo_stage1_latency: got %0d expected 7", n); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (rstn_o !== 3'b011 || stage_idx_o !== 2'd1) begin errors++; $display("FAIL ooo_done2_ignored: got %b idx %0d expected 011 idx 1", rstn_o, stage_idx_o); end
        stage_done_i[1] = 1'b1;
        wait_for(0, 3'b111, 20, n);
        checks++; if (n !== 7) begin errors++; $display("FAIL ooo_stage2_latency: got %0d expected 7", n); end
        wait_for(1, 3'b000, 10, n);
        checks++; if (n < 0 || n > SYNC_STAGES) begin errors++; $display("FAIL ooo_done2_accept: got %0d expected 0..%0d", n, SYNC_STAGES); end
        checks++; if (state_o !== RUN) begin errors++; $display("FAIL ooo_state_run: got %0d expected %0d", state_o, RUN); end
    endtask

    initial begin
        test_reset();
        test_nominal_boot();
        test_lock_loss();
        test_key_bounce();
        test_soft_vs_done();
        test_timeout();
        test_out_of_order_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
